// File: rtl/mem_wb.sv
// Memory-access stage plus MEM/WB pipeline register: byte-enabled data RAM with
// synchronous read, load extension on the registered word, and the writeback triple.
module mem_wb #(
  parameter int DMEM_AW = 10,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_next_i,
  input  logic [31:0]      alu_i,
  input  logic [31:0]      data_i,
  input  logic [4:0]       wbaddr_now_i,
  input  logic [31:0]      instr_i,
  output logic             wb_en_o,
  output logic [4:0]       wb_addr_o,
  output logic [31:0]      wb_data_o,
  output logic             ls_err_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {CLS_NONE, CLS_LOAD, CLS_JUMP, CLS_ALU} wb_cls_t;

  logic [31:0]        mem [0:(2**DMEM_AW)-1];

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic [1:0]         off;
  logic [DMEM_AW-1:0] widx;
  logic               is_load, is_store, aligned, ld_f3_ok, st_f3_ok;
  logic               ld_ok, st_ok, ls_err;
  wb_cls_t            cls_d;
  logic [3:0]         be;
  logic [31:0]        wdata;
  logic               unused_bits;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign off    = alu_i[1:0];
  assign widx   = alu_i[DMEM_AW+1:2];
  assign unused_bits = ^{alu_i[31:DMEM_AW+2], instr_i[31:15], instr_i[11:7]};

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign ld_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
  assign st_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);

  // Access size comes from funct3[1:0] for both loads and stores.
  always_comb begin
    aligned = 1'b0;
    case (funct3[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign ld_ok  = is_load  && ld_f3_ok && aligned;
  assign st_ok  = is_store && st_f3_ok && aligned;
  assign ls_err = (is_load && !ld_ok) || (is_store && !st_ok);

  always_comb begin
    cls_d = CLS_NONE;
    case (opcode)
      OP_LOAD:                          cls_d = ld_ok ? CLS_LOAD : CLS_NONE;
      OP_JAL, OP_JALR:                  cls_d = CLS_JUMP;
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: cls_d = CLS_ALU;
      default:                          cls_d = CLS_NONE;
    endcase
  end

  always_comb begin
    be    = 4'b0000;
    wdata = data_i;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << off;
        wdata = {4{data_i[7:0]}};
      end
      2'b01: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data_i[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  // RAM is not reset; a reset coinciding with a store edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && st_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  logic [31:0]      rdata_q, pc_q, alu_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  wb_cls_t          cls_q;
  logic [4:0]       rd_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cls_q   <= CLS_NONE;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      rdata_q <= mem[widx];
      pc_q    <= pc_next_i;
      alu_q   <= alu_i;
      f3_q    <= funct3;
      off_q   <= off;
      cls_q   <= cls_d;
      rd_q    <= wbaddr_now_i;
      err_q   <= ls_err;
      if (instr_i != 32'd0) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  logic [15:0] lane;
  logic [31:0] load_val;

  always_comb begin
    lane     = 16'(rdata_q >> {off_q, 3'b000});
    load_val = '0;
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b010:  load_val = rdata_q;
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    wb_data_o = '0;
    case (cls_q)
      CLS_LOAD: wb_data_o = load_val;
      CLS_JUMP: wb_data_o = pc_q;
      CLS_ALU:  wb_data_o = alu_q;
      default:  wb_data_o = '0;
    endcase
  end

  assign wb_en_o      = (cls_q != CLS_NONE) && (rd_q != 5'd0);
  assign wb_addr_o    = rd_q;
  assign ls_err_o     = err_q;
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// Bench for mem_wb: directed vector table, reset corner cases, and random traffic
// checked against a byte-addressed memory model.
module tb_mem_wb;

  localparam int CNT_W = 6;

  logic             clk;
  logic             reset;
  logic [31:0]      pc_next_i, alu_i, data_i, instr_i;
  logic [4:0]       wbaddr_now_i;
  logic             wb_en_o;
  logic [4:0]       wb_addr_o;
  logic [31:0]      wb_data_o;
  logic             ls_err_o;
  logic [CNT_W-1:0] retire_cnt_o;

  mem_wb #(.DMEM_AW(10), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .pc_next_i(pc_next_i), .alu_i(alu_i), .data_i(data_i),
    .wbaddr_now_i(wbaddr_now_i), .instr_i(instr_i),
    .wb_en_o(wb_en_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .ls_err_o(ls_err_o), .retire_cnt_o(retire_cnt_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, OP = 7'b0110011, OPIMM = 7'b0010011,
                         LUI = 7'b0110111, AUIPC = 7'b0010111, BRANCH = 7'b1100011,
                         SYSTEM = 7'b1110011;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0]  bm [0:4095];
  logic [31:0] exp_cnt = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [31:0] data;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        e_en;
    logic [31:0] e_data;
    logic        e_err;
    logic        chk_data;
  } vec_t;

  vec_t tab[$];

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
    return {17'h1, f3, 5'd0, op};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver + reference model: one instruction through MEM, outputs checked after the edge
  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] pc, input logic [4:0] rd);
    logic [6:0]  op;
    logic [2:0]  f3;
    int          ba, sz;
    bit          is_ld, is_st, legal, aligned, jump, alu_c, e_en, e_err, chk_d;
    logic [31:0] v, e_data;
    op = ins[6:0];
    f3 = ins[14:12];
    ba = int'(a % 32'd4096);
    sz = 1 << f3[1:0];
    is_ld = (op == LOAD);
    is_st = (op == STORE);
    aligned = (ba % sz) == 0;
    legal = is_ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 <= 3'd2);
    e_err = (is_ld || is_st) && !(legal && aligned);
    v = 0;
    if (is_ld && !e_err) begin
      for (int k = 0; k < sz; k++) v = v | (32'(bm[ba+k]) << (8*k));
      if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    end
    jump  = (op == JAL) || (op == JALR);
    alu_c = (op == OP) || (op == OPIMM) || (op == LUI) || (op == AUIPC);
    e_en  = (rd != 0) && ((is_ld && !e_err) || jump || alu_c);
    e_data = (is_ld && !e_err) ? v : jump ? pc : alu_c ? a : 32'd0;
    chk_d = !(is_ld && e_err);

    instr_i = ins; alu_i = a; data_i = d; pc_next_i = pc; wbaddr_now_i = rd;
    @(posedge clk);
    #1;
    if (is_st && !e_err)
      for (int k = 0; k < sz; k++) bm[ba+k] = 8'(d >> (8*k));
    if (ins != 0) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);

    chk("wb_en", 32'(wb_en_o), 32'(e_en));
    chk("wb_addr", 32'(wb_addr_o), 32'(rd));
    chk("ls_err", 32'(ls_err_o), 32'(e_err));
    chk("retire_cnt", 32'(retire_cnt_o), exp_cnt);
    if (chk_d) chk("wb_data", wb_data_o, e_data);
  endtask

  task automatic idle_check(input string nm);
    chk({nm, "_en"}, 32'(wb_en_o), 32'd0);
    chk({nm, "_addr"}, 32'(wb_addr_o), 32'd0);
    chk({nm, "_data"}, wb_data_o, 32'd0);
    chk({nm, "_err"}, 32'(ls_err_o), 32'd0);
    chk({nm, "_cnt"}, 32'(retire_cnt_o), 32'd0);
  endtask

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    logic [2:0] f3;
    logic [31:0] r, ins;

    for (int i = 0; i < 4096; i++) bm[i] = 8'h00;
    reset = 1'b1;
    instr_i = 0; alu_i = 0; data_i = 0; pc_next_i = 0; wbaddr_now_i = 0;
    repeat (2) @(posedge clk);
    #1;
    idle_check("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      idle_check("after_reset");
    end

    // directed vectors
    tab.push_back('{mk(STORE, 3'b010), 32'h10, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b010),  32'h10, 32'h0, 32'h0, 5'd5, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
    tab.push_back('{mk(STORE, 3'b000), 32'h13, 32'h12345680, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b000),  32'h13, 32'h0, 32'h0, 5'd6, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b100),  32'h13, 32'h0, 32'h0, 5'd7, 1'b1, 32'h00000080, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b010),  32'h10, 32'h0, 32'h0, 5'd8, 1'b1, 32'h80ADBEEF, 1'b0, 1'b1});
    tab.push_back('{mk(OPIMM, 3'b000), 32'h1234, 32'h0, 32'h0, 5'd0, 1'b0, 32'h1234, 1'b0, 1'b1});
    tab.push_back('{mk(JAL, 3'b000),   32'h0, 32'h0, 32'h104, 5'd1, 1'b1, 32'h104, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b010),  32'h12, 32'h0, 32'h0, 5'd9, 1'b0, 32'h0, 1'b1, 1'b0});
    tab.push_back('{mk(STORE, 3'b001), 32'h11, 32'hFFFF, 32'h0, 5'd0, 1'b0, 32'h0, 1'b1, 1'b1});
    tab.push_back('{mk(LOAD, 3'b011),  32'h10, 32'h0, 32'h0, 5'd10, 1'b0, 32'h0, 1'b1, 1'b0});
    tab.push_back('{mk(LOAD, 3'b010),  32'h10, 32'h0, 32'h0, 5'd11, 1'b1, 32'h80ADBEEF, 1'b0, 1'b1});
    tab.push_back('{mk(STORE, 3'b001), 32'h12, 32'h1111CAFE, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b001),  32'h12, 32'h0, 32'h0, 5'd12, 1'b1, 32'hFFFFCAFE, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b101),  32'h12, 32'h0, 32'h0, 5'd13, 1'b1, 32'h0000CAFE, 1'b0, 1'b1});
    tab.push_back('{mk(LOAD, 3'b010),  32'h10, 32'h0, 32'h0, 5'd14, 1'b1, 32'hCAFEBEEF, 1'b0, 1'b1});
    tab.push_back('{mk(BRANCH, 3'b000), 32'h55, 32'h0, 32'h200, 5'd3, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{mk(STORE, 3'b010), 32'h20, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1});
    tab.push_back('{mk(JALR, 3'b000),  32'h0, 32'h0, 32'h300, 5'd2, 1'b1, 32'h300, 1'b0, 1'b1});

    foreach (tab[i]) begin
      step(tab[i].instr, tab[i].alu, tab[i].data, tab[i].pc, tab[i].rd);
      chk($sformatf("tab%0d_en", i), 32'(wb_en_o), 32'(tab[i].e_en));
      chk($sformatf("tab%0d_err", i), 32'(ls_err_o), 32'(tab[i].e_err));
      if (tab[i].chk_data) chk($sformatf("tab%0d_data", i), wb_data_o, tab[i].e_data);
      if (i == 1) chk("tab_retire_after_lw", 32'(retire_cnt_o), 32'd2);
    end

    // reset asserted mid-cycle while a store to 0x20 is on the inputs
    instr_i = mk(STORE, 3'b010); alu_i = 32'h20; data_i = 32'h55AA55AA;
    pc_next_i = 32'h0; wbaddr_now_i = 5'd0;
    #3;
    reset = 1'b1;
    #1;
    idle_check("async_reset");
    @(posedge clk);
    #1;
    idle_check("reset_at_store_edge");
    @(negedge clk);
    reset = 1'b0;
    exp_cnt = 0;
    step(mk(LOAD, 3'b010), 32'h20, 32'h0, 32'h0, 5'd4);
    chk("lw_after_suppressed_sw", wb_data_o, 32'h0);

    // random traffic over the first 64 words, high address bits randomised to show wrap
    for (int w = 0; w < 64; w++) step(mk(STORE, 3'b010), 32'(w * 4), $urandom, 32'h0, 5'd0);
    ops = '{LOAD, STORE, JAL, JALR, OP, OPIMM, LUI, AUIPC, BRANCH, SYSTEM, 7'd0};
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 10)];
      if ((op == LOAD || op == STORE) && $urandom_range(0, 3) != 0)
        f3 = (op == LOAD) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
      else
        f3 = 3'($urandom_range(0, 7));
      if (op == LOAD && f3 == 3'd3) f3 = 3'd4;
      r = $urandom;
      ins = (op == 7'd0) ? 32'd0 : {r[31:15], f3, r[11:7], op};
      r = $urandom;
      step(ins, {r[31:12], 4'h0, r[7:0]}, $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
